// File: rtl/dmem_dual_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_dual_port_arbiter
// Description : Shares one single-port data memory between two issue lanes.
//               Round-robin grant of one aligned access per cycle, misaligned
//               requests rejected in-cycle, 1-cycle read data routed back to
//               the requesting lane, saturating per-lane conflict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_dual_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                req0_i,
  input  logic                req1_i,
  input  logic                we0_i,
  input  logic                we1_i,
  input  logic [DATA_W/8-1:0] wstrb0_i,
  input  logic [DATA_W/8-1:0] wstrb1_i,
  input  logic [ADDR_W-1:0]   addr0_i,
  input  logic [ADDR_W-1:0]   addr1_i,
  input  logic [DATA_W-1:0]   wdata0_i,
  input  logic [DATA_W-1:0]   wdata1_i,
  output logic                ready0_o,
  output logic                ready1_o,
  output logic                err0_o,
  output logic                err1_o,
  output logic                rvalid0_o,
  output logic                rvalid1_o,
  output logic [DATA_W-1:0]   rdata0_o,
  output logic [DATA_W-1:0]   rdata1_o,
  output logic                mem_en_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic [CNT_W-1:0]    conflict0_o,
  output logic [CNT_W-1:0]    conflict1_o
);

  localparam int          c_STRB_W  = DATA_W / 8;
  localparam int          c_OFF_W   = $clog2(c_STRB_W);
  localparam [CNT_W-1:0]  c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // rr_ptr_q = 0 favours lane0 when both lanes are eligible
  logic              rr_ptr_q, rr_ptr_d;
  // Outstanding load: valid plus the lane it belongs to
  logic              tag_vld_q, tag_vld_d;
  logic              tag_lane_q, tag_lane_d;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic [CNT_W-1:0]  conflict0_q, conflict1_q;

  logic w_mis0, w_mis1;
  logic w_elig0, w_elig1;
  logic w_gnt0, w_gnt1;

  // Eligibility, round-robin grant and handshake outputs
  always_comb begin
    w_mis0   = |addr0_i[c_OFF_W-1:0];
    w_mis1   = |addr1_i[c_OFF_W-1:0];
    w_elig0  = req0_i & ~w_mis0;
    w_elig1  = req1_i & ~w_mis1;
    w_gnt0   = w_elig0 & (~w_elig1 | ~rr_ptr_q);
    w_gnt1   = w_elig1 & (~w_elig0 |  rr_ptr_q);
    err0_o   = req0_i & w_mis0;
    err1_o   = req1_i & w_mis1;
    // A misaligned request still completes its handshake, just without access
    ready0_o = w_gnt0 | err0_o;
    ready1_o = w_gnt1 | err1_o;
  end

  // Memory port steered from the granted lane; idle port drives zeros
  always_comb begin
    mem_en_o    = w_gnt0 | w_gnt1;
    mem_we_o    = 1'b0;
    mem_wstrb_o = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_gnt0) begin
      mem_we_o    = we0_i;
      mem_wstrb_o = we0_i ? wstrb0_i : '0;
      mem_addr_o  = addr0_i;
      mem_wdata_o = wdata0_i;
    end else if (w_gnt1) begin
      mem_we_o    = we1_i;
      mem_wstrb_o = we1_i ? wstrb1_i : '0;
      mem_addr_o  = addr1_i;
      mem_wdata_o = wdata1_i;
    end
  end

  // Next-state for the priority pointer and the read-return tag
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    if (w_gnt0) rr_ptr_d = 1'b1;
    if (w_gnt1) rr_ptr_d = 1'b0;
    tag_vld_d  = (w_gnt0 & ~we0_i) | (w_gnt1 & ~we1_i);
    tag_lane_d = w_gnt1;
  end

  // Read data is live from the memory during the return cycle and held after
  always_comb begin
    rvalid0_o   = tag_vld_q & ~tag_lane_q;
    rvalid1_o   = tag_vld_q &  tag_lane_q;
    rdata0_o    = rvalid0_o ? mem_rdata_i : rdata0_q;
    rdata1_o    = rvalid1_o ? mem_rdata_i : rdata1_q;
    conflict0_o = conflict0_q;
    conflict1_o = conflict1_q;
  end

  // State registers: pointer, tag, held read data, saturating counters
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_q    <= 1'b0;
      tag_vld_q   <= 1'b0;
      tag_lane_q  <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      conflict0_q <= '0;
      conflict1_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      tag_vld_q  <= tag_vld_d;
      tag_lane_q <= tag_lane_d;
      if (rvalid0_o) rdata0_q <= mem_rdata_i;
      if (rvalid1_o) rdata1_q <= mem_rdata_i;
      if (w_elig0 && !w_gnt0 && (conflict0_q != {CNT_W{1'b1}}))
        conflict0_q <= conflict0_q + c_CNT_ONE;
      if (w_elig1 && !w_gnt1 && (conflict1_q != {CNT_W{1'b1}}))
        conflict1_q <= conflict1_q + c_CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_dual_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_dual_port_arbiter
// Description : Directed bench for dmem_dual_port_arbiter with a small
//               synchronous memory model behind the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_dual_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        req0, req1, we0, we1;
  logic [3:0]  wstrb0, wstrb1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ready0, ready1, err0, err1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        mem_en, mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  conflict0, conflict1;
  logic        mem_clr;

  int checks = 0;
  int errors = 0;

  dmem_dual_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .wstrb0_i(wstrb0), .wstrb1_i(wstrb1), .addr0_i(addr0), .addr1_i(addr1),
    .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ready0_o(ready0), .ready1_o(ready1), .err0_o(err0), .err1_o(err1),
    .rvalid0_o(rvalid0), .rvalid1_o(rvalid1), .rdata0_o(rdata0), .rdata1_o(rdata1),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_wstrb_o(mem_wstrb),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .conflict0_o(conflict0), .conflict1_o(conflict1)
  );

  always #5 clk = ~clk;

  // 16-word memory; unwritten words read back as 0xC0DE_<addr[15:0]>
  logic [31:0] mem_q [0:15];
  logic [15:0] wr_q;
  logic [3:0]  w_idx;
  assign w_idx = mem_addr[5:2];

  always_ff @(posedge clk) begin
    if (mem_clr) begin
      wr_q <= '0;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem_q[w_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        wr_q[w_idx] <= 1'b1;
      end
      mem_rdata <= wr_q[w_idx] ? mem_q[w_idx] : {16'hC0DE, mem_addr[15:0]};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; wstrb0 = 0; wstrb1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    reset_i = 1; mem_clr = 1;
    repeat (2) @(posedge clk);
    #1 reset_i = 0; mem_clr = 0;
    #1;
    check("rst_rvalid0", {31'd0, rvalid0}, 0);
    check("rst_rvalid1", {31'd0, rvalid1}, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_conflict0", {28'd0, conflict0}, 0);
    check("rst_conflict1", {28'd0, conflict1}, 0);
    check("idle_mem_en", {31'd0, mem_en}, 0);
    check("idle_ready0", {31'd0, ready0}, 0);
    check("idle_mem_wstrb", {28'd0, mem_wstrb}, 0);

    // Lane0 store alone
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF; wstrb0 = 4'hF;
    #1;
    check("st_ready0", {31'd0, ready0}, 1);
    check("st_mem_en", {31'd0, mem_en}, 1);
    check("st_mem_we", {31'd0, mem_we}, 1);
    check("st_mem_addr", mem_addr, 32'h10);
    check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("st_mem_wstrb", {28'd0, mem_wstrb}, 32'hF);
    @(posedge clk); #1;
    req0 = 0; we0 = 0; wstrb0 = 0;
    check("st_no_rvalid0", {31'd0, rvalid0}, 0);
    check("st_no_rvalid1", {31'd0, rvalid1}, 0);

    // Lane0 load of the stored word
    req0 = 1; addr0 = 32'h10;
    #1;
    check("ld_ready0", {31'd0, ready0}, 1);
    check("ld_mem_we", {31'd0, mem_we}, 0);
    @(posedge clk); #1;
    req0 = 0;
    check("ld_rvalid0", {31'd0, rvalid0}, 1);
    check("ld_rdata0", rdata0, 32'hDEADBEEF);
    check("ld_rvalid1", {31'd0, rvalid1}, 0);

    // Pointer now favours lane1
    req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h08;
    #1;
    check("rr1_ready1", {31'd0, ready1}, 1);
    check("rr1_ready0", {31'd0, ready0}, 0);
    check("rr1_mem_addr", mem_addr, 32'h08);
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    check("rr1_conflict0", {28'd0, conflict0}, 1);
    check("rr1_rvalid1", {31'd0, rvalid1}, 1);
    check("rr1_rdata1", rdata1, 32'hC0DE0008);

    // Reset, then both lanes load continuously for six cycles
    reset_i = 1;
    @(posedge clk); #1;
    reset_i = 0;
    req0 = 1; req1 = 1; addr0 = 32'h04; addr1 = 32'h08;
    #1;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("dual_ready0_c%0d", c), {31'd0, ready0}, (c % 2 == 0) ? 1 : 0);
      check($sformatf("dual_ready1_c%0d", c), {31'd0, ready1}, (c % 2 == 1) ? 1 : 0);
      @(posedge clk); #1;
      if (c == 5) begin req0 = 0; req1 = 0; end
      check($sformatf("dual_rvalid0_c%0d", c), {31'd0, rvalid0}, (c % 2 == 0) ? 1 : 0);
      check($sformatf("dual_rvalid1_c%0d", c), {31'd0, rvalid1}, (c % 2 == 1) ? 1 : 0);
      if (c % 2 == 0) check($sformatf("dual_rdata0_c%0d", c), rdata0, 32'hC0DE0004);
      else            check($sformatf("dual_rdata1_c%0d", c), rdata1, 32'hC0DE0008);
      #1;
    end
    check("dual_conflict0", {28'd0, conflict0}, 3);
    check("dual_conflict1", {28'd0, conflict1}, 3);
    check("dual_idle_mem_en", {31'd0, mem_en}, 0);

    // Lone misaligned lane0 request
    req0 = 1; addr0 = 32'h02;
    #1;
    check("mis0_err0", {31'd0, err0}, 1);
    check("mis0_ready0", {31'd0, ready0}, 1);
    check("mis0_mem_en", {31'd0, mem_en}, 0);
    @(posedge clk); #1;
    req0 = 0;

    // Lane1 misaligned store alongside a lane0 aligned load
    req1 = 1; we1 = 1; addr1 = 32'h13; wstrb1 = 4'hF; wdata1 = 32'h12345678;
    req0 = 1; we0 = 0; addr0 = 32'h04;
    #1;
    check("mix_err1", {31'd0, err1}, 1);
    check("mix_ready1", {31'd0, ready1}, 1);
    check("mix_ready0", {31'd0, ready0}, 1);
    check("mix_err0", {31'd0, err0}, 0);
    check("mix_mem_en", {31'd0, mem_en}, 1);
    check("mix_mem_we", {31'd0, mem_we}, 0);
    check("mix_mem_addr", mem_addr, 32'h04);
    @(posedge clk); #1;
    req0 = 0; req1 = 0; we1 = 0; wstrb1 = 0;
    check("mix_rvalid0", {31'd0, rvalid0}, 1);
    check("mix_rdata0", rdata0, 32'hC0DE0004);
    check("mix_conflict1", {28'd0, conflict1}, 3);

    // Pointer moved to lane1 by the lane0 grant
    req0 = 1; req1 = 1; addr0 = 32'h04; addr1 = 32'h08;
    #1;
    check("rr2_ready1", {31'd0, ready1}, 1);
    check("rr2_ready0", {31'd0, ready0}, 0);
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    check("rr2_conflict0", {28'd0, conflict0}, 4);

    // Lane1 starved on alternate cycles until its counter saturates
    for (int p = 0; p < 20; p++) begin
      req0 = 1; req1 = 1;
      @(posedge clk); #1;
      req0 = 0;
      @(posedge clk); #1;
      if (p == 11) check("sat_reach15", {28'd0, conflict1}, 15);
    end
    req1 = 0;
    check("sat_hold15", {28'd0, conflict1}, 15);
    check("sat_conflict0", {28'd0, conflict0}, 4);

    // Lane1 load granted in the same cycle reset is asserted
    req1 = 1; we1 = 0; addr1 = 32'h08; reset_i = 1;
    #1;
    check("rstmid_ready1", {31'd0, ready1}, 1);
    @(posedge clk); #1;
    req1 = 0; reset_i = 0;
    check("rstmid_rvalid1", {31'd0, rvalid1}, 0);
    check("rstmid_rvalid0", {31'd0, rvalid0}, 0);
    check("rstmid_rdata0", rdata0, 0);
    check("rstmid_rdata1", rdata1, 0);
    check("rstmid_conflict0", {28'd0, conflict0}, 0);
    check("rstmid_conflict1", {28'd0, conflict1}, 0);
    req0 = 1; req1 = 1; addr0 = 32'h04; addr1 = 32'h08;
    #1;
    check("rstmid_rr_ready0", {31'd0, ready0}, 1);
    check("rstmid_rr_ready1", {31'd0, ready1}, 0);
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    check("rstmid_rvalid0_after", {31'd0, rvalid0}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
